// File: rtl/axil_cmd_master_if.sv
// Command/response stream plus AXI4-Lite channels
// for the one-outstanding command master bridge.
interface axil_cmd_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    CMD_VALID;
  logic                    CMD_READY;
  logic                    CMD_WRITE;
  logic [ADDR_WIDTH-1:0]   CMD_ADDR;
  logic [DATA_WIDTH-1:0]   CMD_WDATA;
  logic [DATA_WIDTH/8-1:0] CMD_WSTRB;

  logic                    RSP_VALID;
  logic                    RSP_READY;
  logic                    RSP_WRITE;
  logic [DATA_WIDTH-1:0]   RSP_RDATA;
  logic [1:0]              RSP_RESP;

  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WVALID;
  logic                    WREADY;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    ARVALID;
  logic                    ARREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR,
    input  CMD_WDATA, CMD_WSTRB,
    output CMD_READY,
    output RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP,
    input  RSP_READY,
    output AWADDR, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WVALID,
    input  WREADY,
    input  BRESP, BVALID,
    output BREADY,
    output ARADDR, ARVALID,
    input  ARREADY,
    input  RDATA, RRESP, RVALID,
    output RREADY
  );

  modport slave (
    output CMD_VALID, CMD_WRITE, CMD_ADDR,
    output CMD_WDATA, CMD_WSTRB,
    input  CMD_READY,
    input  RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP,
    output RSP_READY,
    input  AWADDR, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WVALID,
    output WREADY,
    output BRESP, BVALID,
    input  BREADY,
    input  ARADDR, ARVALID,
    output ARREADY,
    output RDATA, RRESP, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axil_cmd_master.sv
// AXI4-Lite master: one command word in, one AXI read
// or write out, one response word back; counts completions.
module axil_cmd_master #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  axil_cmd_master_if.master      bus,
  output logic [COUNT_WIDTH-1:0] WR_COUNT,
  output logic [COUNT_WIDTH-1:0] RD_COUNT
);

  typedef enum logic [2:0] {
    IDLE,
    WR,
    WB,
    RA,
    RD,
    RSP
  } state_t;

  state_t state;

  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] strb_q;

  logic aw_fin;
  logic w_fin;

  // Address/data regs only load on command accept, so the
  // AXI payload is frozen for as long as any valid is up.
  assign bus.AWADDR = addr_q;
  assign bus.ARADDR = addr_q;
  assign bus.WDATA  = wdata_q;
  assign bus.WSTRB  = strb_q;

  // A channel is finished once its valid has dropped or
  // is handshaking on this edge.
  assign aw_fin = !bus.AWVALID || bus.AWREADY;
  assign w_fin  = !bus.WVALID  || bus.WREADY;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state         <= IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      bus.CMD_READY <= 1'b0;
      bus.RSP_VALID <= 1'b0;
      bus.RSP_WRITE <= 1'b0;
      bus.RSP_RDATA <= '0;
      bus.RSP_RESP  <= 2'b00;
      bus.AWVALID   <= 1'b0;
      bus.WVALID    <= 1'b0;
      bus.BREADY    <= 1'b0;
      bus.ARVALID   <= 1'b0;
      bus.RREADY    <= 1'b0;
      WR_COUNT      <= '0;
      RD_COUNT      <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.CMD_VALID && bus.CMD_READY) begin
            addr_q        <= bus.CMD_ADDR;
            wdata_q       <= bus.CMD_WDATA;
            strb_q        <= bus.CMD_WSTRB;
            bus.CMD_READY <= 1'b0;
            if (bus.CMD_WRITE) begin
              bus.AWVALID <= 1'b1;
              bus.WVALID  <= 1'b1;
              state       <= WR;
            end else begin
              bus.ARVALID <= 1'b1;
              state       <= RA;
            end
          end else begin
            bus.CMD_READY <= 1'b1;
          end
        end
        WR: begin
          if (bus.AWVALID && bus.AWREADY) begin
            bus.AWVALID <= 1'b0;
          end
          if (bus.WVALID && bus.WREADY) begin
            bus.WVALID <= 1'b0;
          end
          if (aw_fin && w_fin) begin
            bus.BREADY <= 1'b1;
            state      <= WB;
          end
        end
        WB: begin
          if (bus.BVALID && bus.BREADY) begin
            bus.BREADY    <= 1'b0;
            bus.RSP_RESP  <= bus.BRESP;
            bus.RSP_WRITE <= 1'b1;
            bus.RSP_RDATA <= '0;
            bus.RSP_VALID <= 1'b1;
            WR_COUNT      <= WR_COUNT + 1'b1;
            state         <= RSP;
          end
        end
        RA: begin
          if (bus.ARVALID && bus.ARREADY) begin
            bus.ARVALID <= 1'b0;
            bus.RREADY  <= 1'b1;
            state       <= RD;
          end
        end
        RD: begin
          if (bus.RVALID && bus.RREADY) begin
            bus.RREADY    <= 1'b0;
            bus.RSP_RESP  <= bus.RRESP;
            bus.RSP_WRITE <= 1'b0;
            bus.RSP_RDATA <= bus.RDATA;
            bus.RSP_VALID <= 1'b1;
            RD_COUNT      <= RD_COUNT + 1'b1;
            state         <= RSP;
          end
        end
        RSP: begin
          if (bus.RSP_READY) begin
            bus.RSP_VALID <= 1'b0;
            bus.CMD_READY <= 1'b1;
            state         <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axil_cmd_master.sv
// Bench for axil_cmd_master: AXI-Lite memory slave with
// random readiness, table vectors, random ops, corner cases.
module tb_axil_cmd_master;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;
  always #5 ACLK = ~ACLK;

  int cyc = 0;
  always @(posedge ACLK) cyc <= cyc + 1;

  axil_cmd_master_if bus ();
  axil_cmd_master_if bus2 ();

  logic [15:0] wr_count, rd_count;
  logic [1:0]  wr_count2, rd_count2;

  axil_cmd_master u_dut (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .bus      (bus),
    .WR_COUNT (wr_count),
    .RD_COUNT (rd_count)
  );

  axil_cmd_master #(.COUNT_WIDTH(2)) u_wrap (
    .ACLK     (ACLK),
    .ARESETn  (ARESETn),
    .bus      (bus2),
    .WR_COUNT (wr_count2),
    .RD_COUNT (rd_count2)
  );

  // always-ready, always-OKAY slave for the wrap instance
  assign bus2.AWREADY = 1'b1;
  assign bus2.WREADY  = 1'b1;
  assign bus2.BVALID  = 1'b1;
  assign bus2.BRESP   = 2'b00;
  assign bus2.ARREADY = 1'b1;
  assign bus2.RVALID  = 1'b1;
  assign bus2.RDATA   = 32'h0;
  assign bus2.RRESP   = 2'b00;

  int n_checks = 0;
  int n_pass = 0;

  task automatic check(input string name,
                       input logic [255:0] act,
                       input logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  name, act, exp);
  endtask

  // ---------------- AXI-Lite memory slave ----------------
  bit hold_aw = 1'b0;
  logic aw_got, w_got, ar_got;
  logic [31:0] aw_a, w_d, ar_a;
  logic [3:0] w_s;
  logic [31:0] smem [0:63];

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      bus.AWREADY <= 1'b0;
      bus.WREADY  <= 1'b0;
      bus.BVALID  <= 1'b0;
      bus.BRESP   <= 2'b00;
      bus.ARREADY <= 1'b0;
      bus.RVALID  <= 1'b0;
      bus.RDATA   <= 32'h0;
      bus.RRESP   <= 2'b00;
      aw_got <= 1'b0;
      w_got  <= 1'b0;
      ar_got <= 1'b0;
    end else begin
      bus.AWREADY <= !aw_got && !hold_aw &&
                     !(bus.AWVALID && bus.AWREADY) && rnd();
      if (bus.AWVALID && bus.AWREADY) begin
        aw_got <= 1'b1;
        aw_a   <= bus.AWADDR;
      end
      bus.WREADY <= !w_got &&
                    !(bus.WVALID && bus.WREADY) && rnd();
      if (bus.WVALID && bus.WREADY) begin
        w_got <= 1'b1;
        w_d   <= bus.WDATA;
        w_s   <= bus.WSTRB;
      end
      if (bus.BVALID && bus.BREADY) begin
        bus.BVALID <= 1'b0;
      end else if (aw_got && w_got && !bus.BVALID && rnd()) begin
        if (aw_a < 32'h100)
          for (int b = 0; b < 4; b++)
            if (w_s[b]) smem[aw_a[7:2]][8*b +: 8] <= w_d[8*b +: 8];
        bus.BRESP  <= (aw_a < 32'h100) ? 2'd0 : 2'd2;
        bus.BVALID <= 1'b1;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      bus.ARREADY <= !ar_got && !bus.RVALID &&
                     !(bus.ARVALID && bus.ARREADY) && rnd();
      if (bus.ARVALID && bus.ARREADY) begin
        ar_got <= 1'b1;
        ar_a   <= bus.ARADDR;
      end
      if (bus.RVALID && bus.RREADY) begin
        bus.RVALID <= 1'b0;
      end else if (ar_got && !bus.RVALID && rnd()) begin
        bus.RDATA  <= (ar_a < 32'h100) ? smem[ar_a[7:2]] : 32'h0;
        bus.RRESP  <= (ar_a < 32'h100) ? 2'd0 : 2'd2;
        bus.RVALID <= 1'b1;
        ar_got <= 1'b0;
      end
    end
  end

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [0:63];
  logic [15:0] exp_wr = 16'd0;
  logic [15:0] exp_rd = 16'd0;

  task automatic model(input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] s,
                       output logic [31:0] er,
                       output logic [1:0] ep);
    logic [31:0] m;
    logic ok;
    ok = (a < 32'h100);
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    ep = ok ? 2'd0 : 2'd2;
    er = 32'h0;
    if (ok && wr)
      ref_mem[a[7:2]] = (ref_mem[a[7:2]] & ~m) | (d & m);
    if (ok && !wr) er = ref_mem[a[7:2]];
  endtask

  // ---------------- command driver ----------------
  task automatic run_cmd(input logic wr, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] s,
                         input int hold,
                         output logic [31:0] rdata,
                         output logic [1:0] resp,
                         output logic rwr);
    int t;
    bit ok;
    logic [34:0] snap;
    rdata = 'x;
    resp = 'x;
    rwr = 'x;
    @(posedge ACLK); #1;
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = wr;
    bus.CMD_ADDR  = a;
    bus.CMD_WDATA = d;
    bus.CMD_WSTRB = s;
    t = 0;
    forever begin
      @(negedge ACLK);
      if (bus.CMD_READY) break;
      if (++t > 50) begin
        check("cmd_accept_timeout", 0, 1);
        bus.CMD_VALID = 1'b0;
        return;
      end
    end
    @(posedge ACLK); #1;
    bus.CMD_VALID = 1'b0;
    bus.CMD_ADDR  = $urandom;
    bus.CMD_WDATA = $urandom;
    bus.CMD_WSTRB = 4'($urandom);
    @(negedge ACLK);
    check("axi_valid_next_cycle",
          {bus.AWVALID, bus.WVALID, bus.ARVALID},
          wr ? 3'b110 : 3'b001);
    t = 0;
    while (!bus.RSP_VALID) begin
      if (++t > 100) begin
        check("rsp_timeout", 0, 1);
        return;
      end
      @(negedge ACLK);
    end
    if (wr) exp_wr++;
    else exp_rd++;
    check("wr_count", wr_count, exp_wr);
    check("rd_count", rd_count, exp_rd);
    rdata = bus.RSP_RDATA;
    resp = bus.RSP_RESP;
    rwr = bus.RSP_WRITE;
    snap = {bus.RSP_WRITE, bus.RSP_RDATA, bus.RSP_RESP};
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge ACLK);
      if (!bus.RSP_VALID || bus.CMD_READY ||
          bus.AWVALID || bus.WVALID || bus.ARVALID ||
          snap != {bus.RSP_WRITE, bus.RSP_RDATA, bus.RSP_RESP})
        ok = 1'b0;
    end
    if (hold > 0) check("rsp_backpressure_hold", ok, 1);
    @(posedge ACLK); #1;
    bus.RSP_READY = 1'b1;
    @(posedge ACLK); #1;
    bus.RSP_READY = 1'b0;
    @(negedge ACLK);
    check("cmd_ready_after_rsp",
          {bus.CMD_READY, bus.RSP_VALID}, 2'b10);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          hold;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  vec_t tbl [8];

  initial begin
    logic [31:0] rd, er;
    logic [1:0]  rs, ep;
    logic        rw;
    logic [31:0] a, d;
    logic [3:0]  s;
    logic        w;
    int t, last_rsp, ncmd, nrsp, hs;
    logic [1:0] last2;
    logic [1:0] seq [$];
    logic [1:0] wrap_exp [5];

    tbl[0] = '{1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, 32'h0, 2'd0};
    tbl[1] = '{1'b0, 32'h10, 32'h0, 4'h0, 0, 32'hDEAD_BEEF, 2'd0};
    tbl[2] = '{1'b1, 32'h20, 32'h1122_3344, 4'hF, 0, 32'h0, 2'd0};
    tbl[3] = '{1'b1, 32'h20, 32'h0000_AAAA, 4'h3, 1, 32'h0, 2'd0};
    tbl[4] = '{1'b0, 32'h20, 32'h0, 4'h0, 0, 32'h1122_AAAA, 2'd0};
    tbl[5] = '{1'b1, 32'h204, 32'h1234_5678, 4'hF, 0, 32'h0, 2'd2};
    tbl[6] = '{1'b0, 32'h204, 32'h0, 4'h0, 2, 32'h0, 2'd2};
    tbl[7] = '{1'b0, 32'h10, 32'h0, 4'h0, 20, 32'hDEAD_BEEF, 2'd0};
    wrap_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    for (int i = 0; i < 64; i++) begin
      smem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    bus.CMD_VALID = 1'b0;
    bus.CMD_WRITE = 1'b0;
    bus.CMD_ADDR  = 32'h0;
    bus.CMD_WDATA = 32'h0;
    bus.CMD_WSTRB = 4'h0;
    bus.RSP_READY = 1'b0;
    bus2.CMD_VALID = 1'b0;
    bus2.CMD_WRITE = 1'b1;
    bus2.CMD_ADDR  = 32'h0;
    bus2.CMD_WDATA = 32'h0;
    bus2.CMD_WSTRB = 4'hF;
    bus2.RSP_READY = 1'b1;

    // reset state
    repeat (3) @(negedge ACLK);
    check("reset_outputs",
          {bus.CMD_READY, bus.RSP_VALID, bus.RSP_WRITE,
           bus.RSP_RDATA, bus.RSP_RESP, bus.AWADDR, bus.AWVALID,
           bus.WDATA, bus.WSTRB, bus.WVALID, bus.BREADY,
           bus.ARADDR, bus.ARVALID, bus.RREADY,
           wr_count, rd_count}, 0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    @(negedge ACLK);
    check("cmd_ready_after_reset", bus.CMD_READY, 1);

    // back-to-back alternating write/read
    @(posedge ACLK); #1;
    bus.RSP_READY = 1'b1;
    ncmd = 0;
    nrsp = 0;
    last_rsp = -1;
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = 1'b1;
    bus.CMD_ADDR  = 32'h0;
    bus.CMD_WDATA = 32'hA5A5_0000;
    bus.CMD_WSTRB = 4'hF;
    t = 0;
    while (nrsp < 8 && t < 400) begin
      @(negedge ACLK);
      t++;
      hs = 0;
      if (bus.CMD_VALID && bus.CMD_READY) begin
        if (last_rsp >= 0)
          check("b2b_accept_gap", cyc + 1 - last_rsp, 1);
        model(bus.CMD_WRITE, bus.CMD_ADDR, bus.CMD_WDATA,
              bus.CMD_WSTRB, er, ep);
        hs = 1;
      end
      if (bus.RSP_VALID && bus.RSP_READY) begin
        last_rsp = cyc + 1;
        if (!bus.RSP_WRITE)
          check("b2b_read_data", bus.RSP_RDATA,
                {28'h0, nrsp[3:1], 2'b00} ^ 32'hA5A5_0000);
        nrsp++;
      end
      @(posedge ACLK); #1;
      if (hs) begin
        ncmd++;
        a = 32'(ncmd / 2) * 4;
        bus.CMD_VALID = (ncmd < 8);
        bus.CMD_WRITE = !ncmd[0];
        bus.CMD_ADDR  = a;
        bus.CMD_WDATA = a ^ 32'hA5A5_0000;
      end
    end
    check("b2b_done", nrsp, 8);
    bus.CMD_VALID = 1'b0;
    bus.RSP_READY = 1'b0;
    exp_wr = 16'd4;
    exp_rd = 16'd4;
    @(negedge ACLK);
    check("b2b_counts", {wr_count, rd_count}, {16'd4, 16'd4});

    // table vectors
    for (int i = 0; i < 8; i++) begin
      model(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb,
            er, ep);
      run_cmd(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].strb,
              tbl[i].hold, rd, rs, rw);
      check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rdata);
      check($sformatf("tbl%0d_resp", i), rs, tbl[i].exp_resp);
      check($sformatf("tbl%0d_write", i), rw, tbl[i].wr);
    end

    // randomized traffic against the model
    for (int i = 0; i < 40; i++) begin
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0)
        a = 32'h100 + 32'($urandom_range(0, 15)) * 4;
      else
        a = 32'($urandom_range(0, 63)) * 4;
      d = $urandom;
      s = 4'($urandom);
      model(w, a, d, s, er, ep);
      run_cmd(w, a, d, s, $urandom_range(0, 3), rd, rs, rw);
      check("rnd_rdata", rd, er);
      check("rnd_resp", rs, ep);
      check("rnd_write", rw, w);
    end

    // reset in the middle of a write
    hold_aw = 1'b1;
    @(posedge ACLK); #1;
    bus.CMD_VALID = 1'b1;
    bus.CMD_WRITE = 1'b1;
    bus.CMD_ADDR  = 32'h8;
    bus.CMD_WDATA = 32'hFFFF_FFFF;
    bus.CMD_WSTRB = 4'hF;
    t = 0;
    do begin
      @(negedge ACLK);
      if (bus.CMD_VALID && bus.CMD_READY) begin
        @(posedge ACLK); #1;
        bus.CMD_VALID = 1'b0;
      end
      t++;
    end while (!bus.AWVALID && t < 50);
    check("awvalid_before_reset", bus.AWVALID, 1);
    ARESETn = 1'b0;
    #1;
    check("reset_mid_write_outputs",
          {bus.CMD_READY, bus.RSP_VALID, bus.RSP_WRITE,
           bus.RSP_RDATA, bus.RSP_RESP, bus.AWADDR, bus.AWVALID,
           bus.WDATA, bus.WSTRB, bus.WVALID, bus.BREADY,
           bus.ARADDR, bus.ARVALID, bus.RREADY,
           wr_count, rd_count}, 0);
    bus.CMD_VALID = 1'b0;
    hold_aw = 1'b0;
    exp_wr = 16'd0;
    exp_rd = 16'd0;
    @(negedge ACLK);
    ARESETn = 1'b1;
    model(1'b1, 32'h8, 32'h5A5A_5A5A, 4'hF, er, ep);
    run_cmd(1'b1, 32'h8, 32'h5A5A_5A5A, 4'hF, 0, rd, rs, rw);
    check("post_reset_wr_resp", rs, 0);
    run_cmd(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, rs, rw);
    check("post_reset_rdata", rd, 32'h5A5A_5A5A);
    check("post_reset_counts", {wr_count, rd_count},
          {16'd1, 16'd1});

    // 2-bit counter wrap on the second instance
    last2 = wr_count2;
    hs = 0;
    @(posedge ACLK); #1;
    bus2.CMD_VALID = 1'b1;
    t = 0;
    while (seq.size() < 5 && t < 200) begin
      @(negedge ACLK);
      t++;
      if (bus2.CMD_VALID && bus2.CMD_READY) hs++;
      if (wr_count2 != last2) begin
        seq.push_back(wr_count2);
        last2 = wr_count2;
      end
      @(posedge ACLK); #1;
      if (hs >= 5) bus2.CMD_VALID = 1'b0;
    end
    check("wrap_len", seq.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < seq.size())
        check($sformatf("wrap_seq%0d", i), seq[i], wrap_exp[i]);
    check("wrap_rd_count", rd_count2, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
